// File: rtl/adc_fifo_in_sync_pkg.sv
// Shared ADC input-path constants: data widths, FIFO depth, ready threshold
// and the derived 96->32 width-conversion sizes.
package pkg_adc_defines;
  localparam int ADC_FIFO_IN_WIDTH_WRITE_DATA    = 96;
  localparam int ADC_FIFO_IN_WIDTH_READ_DATA     = 32;
  localparam int ADC_FIFO_IN_CNT_WORDS           = 128;
  localparam int VALUE_CNT_FIFO_IN_REDY_FOR_READ = 64;
  localparam int ADC_FIFO_IN_RATIO               = 3;
  localparam int ADC_FIFO_IN_SUBIDX_W            = 2;
  localparam int ADC_FIFO_IN_AVAIL_W             = 9;
endpackage

// File: rtl/adc_fifo_in_sync_ram.sv
// Simple dual-port RAM, one write and one registered read port; isolated so a
// vendor macro can replace it. No reset on the array or read register.
module adc_fifo_in_ram #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/adc_fifo_in_sync.sv
// 96->32 width-converting input FIFO with occupancy counters and sticky error flags; read data 1 cycle after rd_en.
// Optional saturating error counters (ovf_cnt/udf_cnt) under ADC_FIFO_IN_ERR_CNT_EN.
module adc_fifo_in_sync
  import pkg_adc_defines::*;
#(
  parameter int WR_WIDTH      = ADC_FIFO_IN_WIDTH_WRITE_DATA,
  parameter int RD_WIDTH      = ADC_FIFO_IN_WIDTH_READ_DATA,
  parameter int DEPTH         = ADC_FIFO_IN_CNT_WORDS,
  parameter int RDY_THRESHOLD = VALUE_CNT_FIFO_IN_REDY_FOR_READ
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           wr_en,
  input  logic [WR_WIDTH-1:0]            wr_data,
  output logic                           full,
  input  logic                           rd_en,
  output logic [RD_WIDTH-1:0]            rd_data,
  output logic                           rd_valid,
  output logic                           empty,
  output logic                           ready_for_read,
  output logic [$clog2(DEPTH):0]         words_used,
  output logic [ADC_FIFO_IN_AVAIL_W-1:0] rd_words_avail,
  output logic                           overflow,
  output logic                           underflow
`ifdef ADC_FIFO_IN_ERR_CNT_EN
  ,
  output logic [15:0]                    ovf_cnt,
  output logic [15:0]                    udf_cnt
`endif
);
  localparam int RATIO = WR_WIDTH / RD_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int UW    = AW + 1;
  localparam int SW    = ADC_FIFO_IN_SUBIDX_W;
  localparam int VW    = ADC_FIFO_IN_AVAIL_W;

  logic [AW-1:0]       r_wp, r_rp;
  logic [SW-1:0]       r_sub, r_sel;
  logic [UW-1:0]       r_used;
  logic [VW-1:0]       r_avail;
  logic                r_full, r_empty, r_rfr, r_rd_valid, r_ovf, r_udf;

  logic                w_wr_acc, w_rd_acc, w_release;
  logic [UW-1:0]       w_used_nxt;
  logic [VW-1:0]       w_avail_nxt;
  logic [WR_WIDTH-1:0] w_ram_q;
  logic [RD_WIDTH-1:0] w_slice;

  // full/empty come from the current registered state, so a write at full is
  // rejected even when the same cycle releases the last slice of a word.
  always_comb begin
    w_wr_acc    = wr_en & ~r_full & ~flush;
    w_rd_acc    = rd_en & ~r_empty & ~flush;
    w_release   = w_rd_acc & (r_sub == SW'(RATIO - 1));
    w_used_nxt  = r_used;
    if (w_wr_acc && !w_release)      w_used_nxt = r_used + UW'(1);
    else if (!w_wr_acc && w_release) w_used_nxt = r_used - UW'(1);
    w_avail_nxt = r_avail + (w_wr_acc ? VW'(RATIO) : VW'(0)) - (w_rd_acc ? VW'(1) : VW'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_sub      <= '0;
      r_sel      <= '0;
      r_used     <= '0;
      r_avail    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_rfr      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else if (flush) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_sub      <= '0;
      r_used     <= '0;
      r_avail    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_rfr      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_acc) r_wp <= r_wp + AW'(1);
      if (w_rd_acc) begin
        r_sel <= r_sub;
        if (w_release) begin
          r_sub <= '0;
          r_rp  <= r_rp + AW'(1);
        end else begin
          r_sub <= r_sub + SW'(1);
        end
      end
      r_used     <= w_used_nxt;
      r_avail    <= w_avail_nxt;
      r_full     <= (w_used_nxt == UW'(DEPTH));
      r_empty    <= (w_avail_nxt == '0);
      r_rfr      <= (w_used_nxt >= UW'(RDY_THRESHOLD));
      r_rd_valid <= w_rd_acc;
      if (wr_en && r_full)  r_ovf <= 1'b1;
      if (rd_en && r_empty) r_udf <= 1'b1;
    end
  end

`ifdef ADC_FIFO_IN_ERR_CNT_EN
  logic [15:0] r_ovf_cnt, r_udf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_cnt <= '0;
      r_udf_cnt <= '0;
    end else if (!flush) begin
      if (wr_en && r_full && r_ovf_cnt != 16'hFFFF)  r_ovf_cnt <= r_ovf_cnt + 16'd1;
      if (rd_en && r_empty && r_udf_cnt != 16'hFFFF) r_udf_cnt <= r_udf_cnt + 16'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
  assign udf_cnt = r_udf_cnt;
`endif

  adc_fifo_in_ram #(
    .WIDTH (WR_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wp),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rp),
    .o_rd_data (w_ram_q)
  );

  // Slice chosen by the sub-index captured with the read; zero when idle.
  always_comb begin
    w_slice = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (r_sel == SW'(i)) w_slice = w_ram_q[i*RD_WIDTH +: RD_WIDTH];
    end
  end

  assign rd_data        = r_rd_valid ? w_slice : '0;
  assign rd_valid       = r_rd_valid;
  assign full           = r_full;
  assign empty          = r_empty;
  assign ready_for_read = r_rfr;
  assign words_used     = r_used;
  assign rd_words_avail = r_avail;
  assign overflow       = r_ovf;
  assign underflow      = r_udf;
endmodule

// File: tb/tb_adc_fifo_in_sync.sv
// Bench for adc_fifo_in_sync: queue-of-words reference model, read-data
// scoreboard popped by an independent monitor, per-cycle status comparison.
module tb_adc_fifo_in_sync;
  logic        clk = 1'b0;
  logic        rst, flush, wr_en, rd_en;
  logic [95:0] wr_data;
  logic        full, rd_valid, empty, ready_for_read, overflow, underflow;
  logic [31:0] rd_data;
  logic [7:0]  words_used;
  logic [8:0]  rd_words_avail;
`ifdef ADC_FIFO_IN_ERR_CNT_EN
  logic [15:0] ovf_cnt, udf_cnt;
`endif

  always #5 clk = ~clk;

  adc_fifo_in_sync dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .full           (full),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .empty          (empty),
    .ready_for_read (ready_for_read),
    .words_used     (words_used),
    .rd_words_avail (rd_words_avail),
    .overflow       (overflow),
    .underflow      (underflow)
`ifdef ADC_FIFO_IN_ERR_CNT_EN
    ,
    .ovf_cnt        (ovf_cnt),
    .udf_cnt        (udf_cnt)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: stored words as a queue, plus how many slices of the
  // oldest word have already been consumed.
  logic [95:0] mq [$];
  logic [31:0] expq [$];
  int  m_sub = 0;
  bit  m_rv = 0, m_ovf = 0, m_udf = 0, m_just_rst = 0, m_known = 0;
  int  m_ovfc = 0, m_udfc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int m_avail();
    return 3 * mq.size() - m_sub;
  endfunction

  task automatic check_status();
    chk("words_used", longint'(words_used), mq.size());
    chk("rd_words_avail", longint'(rd_words_avail), m_avail());
    chk("full", longint'(full), (mq.size() == 128) ? 1 : 0);
    chk("empty", longint'(empty), (m_avail() == 0) ? 1 : 0);
    chk("ready_for_read", longint'(ready_for_read), (mq.size() >= 64) ? 1 : 0);
    chk("overflow", longint'(overflow), m_ovf);
    chk("underflow", longint'(underflow), m_udf);
    chk("rd_valid", longint'(rd_valid), m_rv);
    if (m_just_rst) chk("rd_data_reset", longint'(rd_data), 0);
`ifdef ADC_FIFO_IN_ERR_CNT_EN
    chk("ovf_cnt", longint'(ovf_cnt), m_ovfc);
    chk("udf_cnt", longint'(udf_cnt), m_udfc);
`endif
  endtask

  task automatic model_update(input bit wr, input logic [95:0] wd, input bit rd,
                              input bit fl, input bit rs);
    int sz, av;
    bit wa, ra;
    logic [95:0] w;
    m_just_rst = rs;
    if (rs) begin
      mq.delete();
      m_sub = 0; m_rv = 0; m_ovf = 0; m_udf = 0; m_ovfc = 0; m_udfc = 0;
    end else if (fl) begin
      mq.delete();
      m_sub = 0; m_rv = 0;
    end else begin
      sz = mq.size();
      av = 3 * sz - m_sub;
      wa = wr && (sz < 128);
      ra = rd && (av > 0);
      if (wr && !wa) begin m_ovf = 1; if (m_ovfc < 65535) m_ovfc++; end
      if (rd && !ra) begin m_udf = 1; if (m_udfc < 65535) m_udfc++; end
      if (ra) begin
        w = mq[0];
        expq.push_back(w[m_sub*32 +: 32]);
        m_sub++;
        if (m_sub == 3) begin mq.delete(0); m_sub = 0; end
      end
      if (wa) mq.push_back(wd);
      m_rv = ra;
    end
  endtask

  // One clock: compare status against the model, then drive the next inputs.
  task automatic step(input bit wr, input logic [95:0] wd, input bit rd,
                      input bit fl = 0, input bit rs = 0);
    @(negedge clk);
    if (m_known) check_status();
    wr_en = wr; wr_data = wd; rd_en = rd; flush = fl; rst = rs;
    model_update(wr, wd, rd, fl, rs);
    if (rs) m_known = 1;
  endtask

  function automatic logic [95:0] rword();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drain();
    for (int k = 0; k < 400 && m_avail() > 0; k++) step(0, '0, 1);
    step(0, '0, 0);
  endtask

  always @(negedge clk) begin
    if (m_known && rd_valid === 1'b1) begin
      if (expq.size() == 0) begin
        n_chk++;
        $display("FAIL rd_data: unexpected rd_valid with data 0x%0h, expected none", rd_data);
      end else begin
        chk("rd_data", longint'(rd_data), longint'(expq.pop_front()));
      end
    end
  end

  initial begin
    logic [95:0] pat;
    rst = 1; flush = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);

    // Single known word, three slices with gaps.
    pat = {12'h008, 12'h007, 12'h006, 12'h005, 12'h004, 12'h003, 12'h002, 12'h001};
    step(1, pat, 0);
    step(0, '0, 1);
    step(0, '0, 0);
    step(0, '0, 1);
    step(0, '0, 1);
    step(0, '0, 0);
    step(0, '0, 0);

    // Threshold: 63 words then the 64th.
    for (int i = 0; i < 64; i++) step(1, rword(), 0);
    step(0, '0, 0);
    drain();

    // Steady streaming across a pointer wrap: ~200 words, reads every cycle.
    step(1, rword(), 0);
    step(1, rword(), 0);
    for (int i = 0; i < 600; i++) step((i % 3) == 0, rword(), 1);
    drain();

    // Empty reads after a clean reset.
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 1);
    step(0, '0, 0);

    // Fill to full, one rejected write, then read everything back.
    for (int i = 0; i < 128; i++) step(1, rword(), 0);
    step(1, rword(), 0);
    step(0, '0, 0);
    drain();

    // Flush after partial activity; sticky flags survive.
    for (int i = 0; i < 10; i++) step(1, rword(), 0);
    step(0, '0, 1);
    step(1, rword(), 1, 1);
    step(0, '0, 0);
    step(0, '0, 1);
    step(0, '0, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 1) == 1, rword(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 199) == 0);
    drain();

    // Reset in the middle of a partially read word.
    for (int i = 0; i < 5; i++) step(1, rword(), 0);
    step(0, '0, 1);
    step(1, rword(), 1, 0, 1);
    step(0, '0, 0);
    step(0, '0, 0);
    step(0, '0, 0);

    chk("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
